// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: four-way intersection phase sequencer driving a companion one-shot timer
// Ports: clk/rst (sync, active-high); ped_req latched crossing request; emerg override level;
//   timer_done from the timer; timer_start/timer_load one-cycle start pulse plus duration;
//   ns_light/ew_light lamps (00 red, 01 yellow, 10 green); walk lamp; phase debug code.
// Optional feature: define EMERG_OVERRIDE_EN to honour emerg (forces the all-red EMERG phase).
module traffic_phase_ctrl #(
    parameter logic [7:0] T_GREEN  = 8'd20,
    parameter logic [7:0] T_YELLOW = 8'd4,
    parameter logic [7:0] T_RED    = 8'd2,
    parameter logic [7:0] T_WALK   = 8'd10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ped_req,
    input  logic       emerg,
    input  logic       timer_done,
    output logic       timer_start,
    output logic [7:0] timer_load,
    output logic [1:0] ns_light,
    output logic [1:0] ew_light,
    output logic       walk,
    output logic [2:0] phase
);
    typedef enum logic [2:0] {
        P_NS_G = 3'd0, P_NS_Y = 3'd1, P_RED_A = 3'd2, P_EW_G = 3'd3,
        P_EW_Y = 3'd4, P_RED_B = 3'd5, P_WALK = 3'd6, P_EMERG = 3'd7
    } phase_e;
    // S_ENTRY is the post-reset state: the next edge emits the ARM pulse of the current phase.
    // S_ARM/S_GAP name the cycle currently visible; done is only sampled in S_WAIT.
    typedef enum logic [1:0] {S_ENTRY, S_ARM, S_GAP, S_WAIT} step_e;

    phase_e     phase_q, phase_d;
    step_e      step_q, step_d;
    logic       start_q, start_d, ped_q, ped_d, walk_q, walk_d;
    logic [7:0] load_q, load_d;
    logic [1:0] ns_q, ns_d, ew_q, ew_d;

    function automatic phase_e ring_next(input phase_e p, input logic ped);
        return (p == P_RED_B) ? (ped ? P_WALK : P_NS_G) :
               (p >= P_WALK)  ? P_NS_G : phase_e'(p + 3'd1);
    endfunction

    function automatic logic [7:0] duration(input phase_e p);
        return (p == P_NS_G || p == P_EW_G) ? T_GREEN  :
               (p == P_NS_Y || p == P_EW_Y) ? T_YELLOW :
               (p == P_WALK)                ? T_WALK   : T_RED;
    endfunction

    always_comb begin
        phase_d = phase_q;
        step_d  = (step_q == S_ARM) ? S_GAP : (step_q == S_GAP) ? S_WAIT : step_q;
        start_d = 1'b0;
        if (step_q == S_ENTRY || (step_q == S_WAIT && timer_done)) begin
            phase_d = (step_q == S_ENTRY) ? phase_q : ring_next(phase_q, ped_q);
            step_d  = S_ARM;
            start_d = 1'b1;
        end
`ifdef EMERG_OVERRIDE_EN
        if (emerg) begin
            phase_d = P_EMERG;
            step_d  = S_WAIT;
            start_d = 1'b0;
        end else if (phase_q == P_EMERG) begin
            phase_d = P_RED_B;
            step_d  = S_ARM;
            start_d = 1'b1;
        end
`endif
        load_d = start_d ? duration(phase_d) : load_q;
        // Entering WALK serves the request; a press on that same edge re-arms it.
        ped_d  = (ped_q && !(start_d && phase_d == P_WALK)) || ped_req;
        ns_d   = (phase_d == P_NS_G) ? 2'b10 : (phase_d == P_NS_Y) ? 2'b01 : 2'b00;
        ew_d   = (phase_d == P_EW_G) ? 2'b10 : (phase_d == P_EW_Y) ? 2'b01 : 2'b00;
        walk_d = (phase_d == P_WALK);
    end

`ifndef EMERG_OVERRIDE_EN
    logic unused_emerg;
    assign unused_emerg = emerg;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= P_RED_B;
            step_q  <= S_ENTRY;
            start_q <= 1'b0;
            load_q  <= 8'd0;
            ped_q   <= 1'b0;
            ns_q    <= 2'b00;
            ew_q    <= 2'b00;
            walk_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            step_q  <= step_d;
            start_q <= start_d;
            load_q  <= load_d;
            ped_q   <= ped_d;
            ns_q    <= ns_d;
            ew_q    <= ew_d;
            walk_q  <= walk_d;
        end
    end

    assign timer_start = start_q;
    assign timer_load  = load_q;
    assign ns_light    = ns_q;
    assign ew_light    = ew_q;
    assign walk        = walk_q;
    assign phase       = phase_q;
endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb_traffic_phase_ctrl: directed bench for traffic_phase_ctrl with companion timer models
module tb_traffic_phase_ctrl;
    logic       clk = 1'b0, rst = 1'b1, rst_b = 1'b1, ped_req = 1'b0, emerg = 1'b0;
    logic       timer_done = 1'b0, b_done = 1'b0;
    logic       timer_start, b_start, walk, b_walk;
    logic [7:0] timer_load, b_load, cnt_a = 8'd0, cnt_b = 8'd0;
    logic [1:0] ns_light, ew_light, b_ns, b_ew;
    logic [2:0] phase, b_phase;
    int         n_cmp = 0, n_bad = 0;

    typedef struct { int ph; int len; int ns; int ew; int wk; int ld; int ped; } rec_t;
    rec_t tbl [22];
    int   b_ph [7] = '{5, 0, 1, 2, 3, 4, 5};
    int   b_len [7] = '{5, 23, 3, 5, 23, 3, 5};
    int   b_ld [7] = '{2, 20, 0, 2, 20, 0, 2};

    always #5 clk = ~clk;

    traffic_phase_ctrl dut (
        .clk(clk), .rst(rst), .ped_req(ped_req), .emerg(emerg), .timer_done(timer_done),
        .timer_start(timer_start), .timer_load(timer_load), .ns_light(ns_light),
        .ew_light(ew_light), .walk(walk), .phase(phase)
    );

    traffic_phase_ctrl #(.T_YELLOW(8'd0)) dut_b (
        .clk(clk), .rst(rst_b), .ped_req(1'b0), .emerg(1'b0), .timer_done(b_done),
        .timer_start(b_start), .timer_load(b_load), .ns_light(b_ns),
        .ew_light(b_ew), .walk(b_walk), .phase(b_phase)
    );

    // Companion one-shot timers: reload on start, count down, sticky done until next start.
    always @(posedge clk) begin
        if (timer_start === 1'b1) begin
            cnt_a <= timer_load;
            timer_done <= 1'b0;
        end else if (cnt_a == 8'd0) timer_done <= 1'b1;
        else cnt_a <= cnt_a - 8'd1;
    end

    always @(posedge clk) begin
        if (b_start === 1'b1) begin
            cnt_b <= b_load;
            b_done <= 1'b0;
        end else if (cnt_b == 8'd0) b_done <= 1'b1;
        else cnt_b <= cnt_b - 8'd1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic rec_t mk(input int ph, len, ns, ew, wk, ld, ped);
        rec_t r;
        r.ph = ph; r.len = len; r.ns = ns; r.ew = ew; r.wk = wk; r.ld = ld; r.ped = ped;
        return r;
    endfunction

    // Entered at the falling edge of a phase's ARM cycle; leaves at the next phase's ARM.
    task automatic run_phase(input rec_t r, input string tag);
        int len = 1, extra = 0, lamp_chg = 0;
        chk($sformatf("%s.phase", tag), 32'(phase), r.ph);
        chk($sformatf("%s.ns", tag), 32'(ns_light), r.ns);
        chk($sformatf("%s.ew", tag), 32'(ew_light), r.ew);
        chk($sformatf("%s.walk", tag), 32'(walk), r.wk);
        chk($sformatf("%s.start", tag), 32'(timer_start), 1);
        chk($sformatf("%s.load", tag), 32'(timer_load), r.ld);
        for (int k = 0; k < 400; k++) begin
            ped_req = (r.ped != 0) && (len == 2);
            @(negedge clk);
            if (phase !== 3'(r.ph)) break;
            len++;
            if (timer_start !== 1'b0) extra++;
            if (ns_light !== 2'(r.ns) || ew_light !== 2'(r.ew) || walk !== 1'(r.wk)) lamp_chg++;
        end
        ped_req = 1'b0;
        chk($sformatf("%s.len", tag), len, r.len);
        chk($sformatf("%s.extra_start", tag), extra, 0);
        chk($sformatf("%s.lamp_glitch", tag), lamp_chg, 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk($sformatf("%s.phase", tag), 32'(phase), 5);
        chk($sformatf("%s.ns", tag), 32'(ns_light), 0);
        chk($sformatf("%s.ew", tag), 32'(ew_light), 0);
        chk($sformatf("%s.walk", tag), 32'(walk), 0);
        chk($sformatf("%s.start", tag), 32'(timer_start), 0);
        chk($sformatf("%s.load", tag), 32'(timer_load), 0);
    endtask

    initial begin
        int len, starts, non_emerg;
        tbl[0]  = mk(5, 5, 0, 0, 0, 2, 0);
        tbl[1]  = mk(0, 23, 2, 0, 0, 20, 0);
        tbl[2]  = mk(1, 7, 1, 0, 0, 4, 0);
        tbl[3]  = mk(2, 5, 0, 0, 0, 2, 0);
        tbl[4]  = mk(3, 23, 0, 2, 0, 20, 0);
        tbl[5]  = mk(4, 7, 0, 1, 0, 4, 0);
        tbl[6]  = mk(5, 5, 0, 0, 0, 2, 0);
        tbl[7]  = mk(0, 23, 2, 0, 0, 20, 0);
        tbl[8]  = mk(1, 7, 1, 0, 0, 4, 0);
        tbl[9]  = mk(2, 5, 0, 0, 0, 2, 0);
        tbl[10] = mk(3, 23, 0, 2, 0, 20, 1);
        tbl[11] = mk(4, 7, 0, 1, 0, 4, 0);
        tbl[12] = mk(5, 5, 0, 0, 0, 2, 0);
        tbl[13] = mk(6, 13, 0, 0, 1, 10, 1);
        tbl[14] = mk(0, 23, 2, 0, 0, 20, 0);
        tbl[15] = mk(1, 7, 1, 0, 0, 4, 0);
        tbl[16] = mk(2, 5, 0, 0, 0, 2, 0);
        tbl[17] = mk(3, 23, 0, 2, 0, 20, 0);
        tbl[18] = mk(4, 7, 0, 1, 0, 4, 0);
        tbl[19] = mk(5, 5, 0, 0, 0, 2, 0);
        tbl[20] = mk(6, 13, 0, 0, 1, 10, 0);
        tbl[21] = mk(0, 23, 2, 0, 0, 20, 0);

        repeat (2) @(negedge clk);
        chk_reset_outputs("por");
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 22; i++) run_phase(tbl[i], $sformatf("ring%0d", i));

        // Reset in the middle of EW_Y with a request pending: the request must be dropped.
        for (int k = 0; k < 200 && phase !== 3'd4; k++) @(negedge clk);
        chk("ewy.reached", 32'(phase), 4);
        @(negedge clk);
        ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs("midrst");
`ifndef EMERG_OVERRIDE_EN
        emerg = 1'b1;
`endif
        rst = 1'b0;
        @(negedge clk);
        run_phase(mk(5, 5, 0, 0, 0, 2, 0), "rst_redb");
        run_phase(mk(0, 23, 2, 0, 0, 20, 0), "rst_nsg");
        emerg = 1'b0;

`ifdef EMERG_OVERRIDE_EN
        for (int k = 0; k < 200 && phase !== 3'd0; k++) @(negedge clk);
        repeat (5) @(negedge clk);
        emerg = 1'b1;
        @(negedge clk);
        chk("emerg.phase", 32'(phase), 7);
        chk("emerg.ns", 32'(ns_light), 0);
        chk("emerg.ew", 32'(ew_light), 0);
        chk("emerg.walk", 32'(walk), 0);
        chk("emerg.start", 32'(timer_start), 0);
        starts = 0;
        non_emerg = 0;
        repeat (9) begin
            @(negedge clk);
            if (timer_start !== 1'b0) starts++;
            if (phase !== 3'd7) non_emerg++;
        end
        chk("emerg.hold_starts", starts, 0);
        chk("emerg.hold_phase", non_emerg, 0);
        emerg = 1'b0;
        @(negedge clk);
        run_phase(mk(5, 5, 0, 0, 0, 2, 0), "emrel_redb");
        run_phase(mk(0, 23, 2, 0, 0, 20, 0), "emrel_nsg");
`endif

        // Second instance with zero-length yellow.
        rst_b = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            len = 1;
            chk($sformatf("ty0_%0d.phase", i), 32'(b_phase), b_ph[i]);
            chk($sformatf("ty0_%0d.start", i), 32'(b_start), 1);
            chk($sformatf("ty0_%0d.load", i), 32'(b_load), b_ld[i]);
            for (int k = 0; k < 400; k++) begin
                @(negedge clk);
                if (b_phase !== 3'(b_ph[i])) break;
                len++;
            end
            chk($sformatf("ty0_%0d.len", i), len, b_len[i]);
        end
        chk("ty0.final_phase", 32'(b_phase), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
